// File: rtl/gnrl_iqdec_pkg.sv
// gnrl_iqdec_pkg
//   Shared definitions for the N-channel IQ boxcar decimator:
//   - ser_state_e : output serializer states (IDLE, SEND)
//   - SEXT_MAX    : widest word the sign-extension helper handles
//   - sign_extend : replicates bit 'msb' of a value into all higher bits;
//                   callers cast the result down to their accumulator width.
package gnrl_iqdec_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // ACC_WIDTH of any instance must not exceed this.
  localparam int unsigned SEXT_MAX = 64;

  function automatic logic [SEXT_MAX-1:0] sign_extend(
    input logic [SEXT_MAX-1:0] val,
    input logic [5:0]          msb
  );
    logic [SEXT_MAX-1:0] res;
    res = val;
    for (int i = 0; i < SEXT_MAX; i++) begin
      if (6'(i) > msb) res[i] = val[msb];
    end
    return res;
  endfunction

endpackage

// File: rtl/gnrl_iqdec_acc.sv
// gnrl_iqdec_acc
//   One channel's I/Q accumulator pair plus the shadow registers that hold
//   the last completed frame while the serializer drains it.
// Ports:
//   CLK        in   system clock, rising edge
//   RESET_n    in   synchronous active-low reset
//   acc_clr    in   clear both accumulators (enable low or frame end)
//   acc_add    in   add the current samples to the accumulators
//   shadow_ld  in   copy acc+sample into the shadow registers
//   sample_i   in   signed in-phase sample
//   sample_q   in   signed quadrature sample
//   sum_i      out  acc_i + sign-extended sample_i (combinational)
//   sum_q      out  acc_q + sign-extended sample_q (combinational)
//   shadow_i   out  registered I sum of the last accepted frame
//   shadow_q   out  registered Q sum of the last accepted frame
module gnrl_iqdec_acc
  import gnrl_iqdec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  acc_clr,
  input  logic                  acc_add,
  input  logic                  shadow_ld,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] sample_q,
  output logic [ACC_WIDTH-1:0]  sum_i,
  output logic [ACC_WIDTH-1:0]  sum_q,
  output logic [ACC_WIDTH-1:0]  shadow_i,
  output logic [ACC_WIDTH-1:0]  shadow_q
);

  logic [ACC_WIDTH-1:0] acc_i;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] ext_i;
  logic [ACC_WIDTH-1:0] ext_q;

  assign ext_i = ACC_WIDTH'(sign_extend(SEXT_MAX'(sample_i), 6'(DATA_WIDTH - 1)));
  assign ext_q = ACC_WIDTH'(sign_extend(SEXT_MAX'(sample_q), 6'(DATA_WIDTH - 1)));

  // The sum including the current sample is what the shadow captures at
  // frame end, and what the top level presents as word 0 of a new frame.
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      acc_i    <= '0;
      acc_q    <= '0;
      shadow_i <= '0;
      shadow_q <= '0;
    end else begin
      if (acc_clr) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (acc_add) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
      end
      if (shadow_ld) begin
        shadow_i <= sum_i;
        shadow_q <= sum_q;
      end
    end
  end

endmodule

// File: rtl/gnrl_iqn_decimator.sv
// gnrl_iqn_decimator
//   N-channel IQ boxcar decimator. Sums dec_fact valid samples per channel
//   and streams the sums as I0, Q0, I1, Q1, ... with valid/ready handshake.
//   A frame that completes while the previous one is still draining is
//   dropped and flagged on the sticky ovf output.
// Optional feature macro: GNRL_IQDEC_DROP_CNT_EN adds the 16-bit saturating
//   drop_cnt output.
// Ports:
//   CLK        in   system clock, rising edge
//   RESET_n    in   synchronous active-low reset
//   enable     in   accumulation enable; low discards the partial frame
//   dataI      in   packed signed I samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dataQ      in   packed signed Q samples, same packing
//   in_valid   in   qualifies dataI/dataQ
//   dec_fact   in   samples per frame, 0 treated as 1
//   dataout    out  serialised signed sum word
//   out_valid  out  dataout valid
//   out_ready  in   downstream accepts the word
//   out_last   out  final word of a frame (Q of the last channel)
//   ovf        out  sticky frame-drop flag
//   drop_cnt   out  dropped-frame counter (GNRL_IQDEC_DROP_CNT_EN only)
//   ovf_clr    in   clears ovf (and drop_cnt)
//
// Serializer states:
//   state   | meaning
//   ST_IDLE | no frame pending, out_valid low
//   ST_SEND | word w of the shadow frame presented on dataout
module gnrl_iqn_decimator
  import gnrl_iqdec_pkg::*;
#(
  parameter  int N_CH       = 2,
  parameter  int DATA_WIDTH = 16,
  parameter  int DEC_WIDTH  = 16,
  localparam int ACC_WIDTH  = DATA_WIDTH + DEC_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RESET_n,
  input  logic                         enable,
  input  logic [N_CH*DATA_WIDTH-1:0]   dataI,
  input  logic [N_CH*DATA_WIDTH-1:0]   dataQ,
  input  logic                         in_valid,
  input  logic [DEC_WIDTH-1:0]         dec_fact,
  output logic signed [ACC_WIDTH-1:0]  dataout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         ovf,
`ifdef GNRL_IQDEC_DROP_CNT_EN
  output logic [15:0]                  drop_cnt,
`endif
  input  logic                         ovf_clr
);

  localparam int W_IDX = $clog2(2 * N_CH);
  localparam logic [W_IDX-1:0]     W_LAST  = W_IDX'(2 * N_CH - 1);
  localparam logic [W_IDX-1:0]     W_ONE   = W_IDX'(1);
  localparam logic [DEC_WIDTH-1:0] DEC_ONE = DEC_WIDTH'(1);

  logic [DEC_WIDTH-1:0] cnt;
  logic [DEC_WIDTH-1:0] dec_l;
  logic [DEC_WIDTH-1:0] dec_fact_eff;
  logic [DEC_WIDTH-1:0] dec_cur;

  logic take;
  logic frame_end;
  logic hs;
  logic final_hs;
  logic accept;
  logic drop;

  ser_state_e           state;
  logic [W_IDX-1:0]     w;
  logic [W_IDX-1:0]     w_nxt;
  logic [ACC_WIDTH-1:0] word_nxt;

  logic [ACC_WIDTH-1:0] sum_i    [N_CH];
  logic [ACC_WIDTH-1:0] sum_q    [N_CH];
  logic [ACC_WIDTH-1:0] shadow_i [N_CH];
  logic [ACC_WIDTH-1:0] shadow_q [N_CH];

  // ---------------------------------------------------------------------
  // Frame counting
  // ---------------------------------------------------------------------
  assign dec_fact_eff = (dec_fact == '0) ? DEC_ONE : dec_fact;

  // At the first sample of a frame dec_l is being loaded on this very edge,
  // so the frame-length compare uses the incoming value directly.
  assign dec_cur = (cnt == '0) ? dec_fact_eff : dec_l;

  assign take      = enable && in_valid;
  assign frame_end = take && (cnt == (dec_cur - DEC_ONE));

  assign hs       = out_valid && out_ready;
  assign final_hs = hs && (w == W_LAST);

  // A new frame is only taken when the serializer is free or finishes the
  // previous frame on the same edge; otherwise it is dropped.
  assign accept = frame_end && ((state == ST_IDLE) || final_hs);
  assign drop   = frame_end && !accept;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cnt   <= '0;
      dec_l <= DEC_ONE;
      ovf   <= 1'b0;
    end else begin
      if (enable && (cnt == '0)) dec_l <= dec_fact_eff;

      if (!enable || frame_end) begin
        cnt <= '0;
      end else if (take) begin
        cnt <= cnt + DEC_ONE;
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef GNRL_IQDEC_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Per-channel accumulators
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    gnrl_iqdec_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .acc_clr   (!enable || frame_end),
      .acc_add   (take),
      .shadow_ld (accept),
      .sample_i  (dataI[k*DATA_WIDTH +: DATA_WIDTH]),
      .sample_q  (dataQ[k*DATA_WIDTH +: DATA_WIDTH]),
      .sum_i     (sum_i[k]),
      .sum_q     (sum_q[k]),
      .shadow_i  (shadow_i[k]),
      .shadow_q  (shadow_q[k])
    );
  end

  // ---------------------------------------------------------------------
  // Output mux: even word index -> I, odd -> Q of channel index/2
  // ---------------------------------------------------------------------
  assign w_nxt = w + W_ONE;

  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_nxt == W_IDX'(2 * k))     word_nxt = shadow_i[k];
      if (w_nxt == W_IDX'(2 * k + 1)) word_nxt = shadow_q[k];
    end
  end

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      w         <= '0;
      dataout   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SEND;
            w         <= '0;
            dataout   <= sum_i[0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (accept) begin
            // back-to-back frame: word 0 comes straight from the new sums
            w        <= '0;
            dataout  <= sum_i[0];
            out_last <= 1'b0;
          end else if (final_hs) begin
            state     <= ST_IDLE;
            w         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (hs) begin
            w        <= w_nxt;
            dataout  <= word_nxt;
            out_last <= (w_nxt == W_LAST);
          end
        end
        default: begin
          state     <= ST_IDLE;
          w         <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnrl_iqn_decimator.sv
// tb_gnrl_iqn_decimator
//   Scoreboard bench for gnrl_iqn_decimator (N_CH=2, 16-bit samples).
//   A reference model collects whole frames of samples and sums them when a
//   frame completes, deciding accept/drop from the number of words still
//   owed downstream. A negedge monitor pops and compares on every handshake.
module tb_gnrl_iqn_decimator;

  localparam int N_CH = 2;
  localparam int DW   = 16;
  localparam int DECW = 16;
  localparam int AW   = DW + DECW;
  localparam int NW   = 2 * N_CH;

  logic                   CLK = 1'b0;
  logic                   RESET_n;
  logic                   enable;
  logic [N_CH*DW-1:0]     dataI;
  logic [N_CH*DW-1:0]     dataQ;
  logic                   in_valid;
  logic [DECW-1:0]        dec_fact;
  logic signed [AW-1:0]   dataout;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   ovf;
  logic                   ovf_clr;
`ifdef GNRL_IQDEC_DROP_CNT_EN
  logic [15:0]            drop_cnt;
`endif

  always #5 CLK = ~CLK;

  gnrl_iqn_decimator #(
    .N_CH       (N_CH),
    .DATA_WIDTH (DW),
    .DEC_WIDTH  (DECW)
  ) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .enable    (enable),
    .dataI     (dataI),
    .dataQ     (dataQ),
    .in_valid  (in_valid),
    .dec_fact  (dec_fact),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .ovf       (ovf),
`ifdef GNRL_IQDEC_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic [AW-1:0] d;
    logic          l;
  } word_t;

  // samples stored in output order: I0, Q0, I1, Q1, ...
  typedef longint vec_t [NW];

  word_t  exp_q[$];
  vec_t   frame[$];
  vec_t   vin;
  word_t  e_w;
  int     flen;
  int     pend = 0;
  int     pb;
  logic   m_hs;
  logic   m_fe;
  logic   m_drop;
  logic   m_ovf = 1'b0;
  int     m_drops = 0;
  longint s_acc;

  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_d;
  logic          stall_l;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: state after each rising edge
  // ---------------------------------------------------------------------
  always @(posedge CLK) begin
    if (!RESET_n) begin
      exp_q.delete();
      frame.delete();
      pend       = 0;
      m_ovf      = 1'b0;
      m_drops    = 0;
      stall_prev = 1'b0;
    end else begin
      m_hs = (pend > 0) && out_ready;
      pb   = pend;
      if (m_hs) pend--;
      m_fe   = 1'b0;
      m_drop = 1'b0;
      if (!enable) begin
        frame.delete();
      end else if (in_valid) begin
        if (frame.size() == 0) flen = (dec_fact == '0) ? 1 : int'(dec_fact);
        for (int k = 0; k < N_CH; k++) begin
          vin[2*k]   = longint'($signed(dataI[k*DW +: DW]));
          vin[2*k+1] = longint'($signed(dataQ[k*DW +: DW]));
        end
        frame.push_back(vin);
        if (frame.size() == flen) m_fe = 1'b1;
      end
      if (m_fe) begin
        if (pb == 0 || (pb == 1 && m_hs)) begin
          for (int j = 0; j < NW; j++) begin
            s_acc = 0;
            foreach (frame[f]) s_acc += frame[f][j];
            exp_q.push_back('{d: AW'(s_acc), l: (j == NW - 1)});
          end
          pend += NW;
        end else begin
          m_drop = 1'b1;
        end
        frame.delete();
      end
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (ovf_clr) m_drops = m_drop ? 1 : 0;
      else if (m_drop && m_drops < 65535) m_drops++;
    end
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge CLK) begin
    chk("out_valid", 64'(out_valid), 64'(pend > 0));
    chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef GNRL_IQDEC_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
    if (stall_prev) begin
      chk("stall_data", 64'($unsigned(dataout)), 64'(stall_d));
      chk("stall_last", 64'(out_last), 64'(stall_l));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word at %0t", dataout, $time);
      end else begin
        e_w = exp_q.pop_front();
        chk("dataout", 64'($unsigned(dataout)), 64'(e_w.d));
        chk("out_last", 64'(out_last), 64'(e_w.l));
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_d    = $unsigned(dataout);
    stall_l    = out_last;
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N_CH; k++) begin
      dataI[k*DW +: DW] = DW'($urandom);
      dataQ[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rand_data();
      tick(1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_dataout"},   64'($unsigned(dataout)), 64'd0);
    chk({tag, "_out_last"},  64'(out_last), 64'd0);
    chk({tag, "_ovf"},       64'(ovf), 64'd0);
  endtask

  initial begin
    RESET_n   = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    dec_fact  = DECW'(4);
    dataI     = '0;
    dataQ     = '0;
    tick(3);
    check_reset_state("reset");
    RESET_n = 1'b1;

    // constant channels: sums 4, -4, 400, -400 per frame
    dataI    = {16'sd100, 16'sd1};
    dataQ    = {-16'sd100, -16'sd1};
    enable   = 1'b1;
    in_valid = 1'b1;
    tick(40);
    chk("const_no_ovf", 64'(ovf), 64'd0);

    // dec_fact 0 acts as 1 with a ramp: a frame per sample, most dropped
    enable = 1'b0;
    tick(6);
    dec_fact = '0;
    enable   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      dataI = {DW'(i + 1000), DW'(i)};
      dataQ = {DW'(-i), DW'(2 * i)};
      tick(1);
    end
    enable = 1'b0;
    tick(6);
    chk("ramp_ovf_set", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // backpressure mid-frame
    dec_fact = DECW'(4);
    enable   = 1'b1;
    rand_cycles(6);
    out_ready = 1'b0;
    rand_cycles(10);
    out_ready = 1'b1;
    rand_cycles(20);

    // dec_fact 4 -> 2 in the middle of a frame
    enable = 1'b0;
    tick(6);
    enable = 1'b1;
    rand_cycles(2);
    dec_fact = DECW'(2);
    rand_cycles(12);

    // enable drop after 3 of 4 samples discards the partial frame
    enable = 1'b0;
    tick(6);
    dec_fact = DECW'(4);
    enable   = 1'b1;
    rand_cycles(3);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    rand_cycles(8);

    // reset during drain with a drop pending in ovf
    out_ready = 1'b0;
    rand_cycles(9);
    RESET_n = 1'b0;
    tick(1);
    RESET_n = 1'b1;
    check_reset_state("mid_drain_reset");
    out_ready = 1'b1;
    rand_cycles(12);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) dec_fact = DECW'($urandom_range(0, 5));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      enable    = ($urandom_range(0, 63) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      rand_data();
      tick(1);
    end

    enable    = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    tick(30);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout: bench still running at %0t, required finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
